// File: rtl/sensor_i2c_pkg.sv
// Shared types and constants for the sensor I2C master: FSM states,
// bit-primitive commands, transfer direction and acknowledge levels.
package sensor_i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START     = 4'd1,
    ST_ADDR      = 4'd2,
    ST_ADDR_ACK  = 4'd3,
    ST_WDATA     = 4'd4,
    ST_WDATA_ACK = 4'd5,
    ST_RDATA     = 4'd6,
    ST_MNACK     = 4'd7,
    ST_STOP      = 4'd8,
    ST_DONE      = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_STOP  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_READ  = 2'd3
  } bit_cmd_e;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;
  localparam logic ACK       = 1'b0;
  localparam logic NACK      = 1'b1;

  function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rw);
    return {addr, rw};
  endfunction

endpackage

// File: rtl/i2c_bit_ctrl.sv
// Quarter-phase sequencer for one I2C bit slot: START, STOP, bit write and
// bit read. Line enables are registered, so each level appears one cycle after its quarter.
module i2c_bit_ctrl
  import sensor_i2c_pkg::*;
#(
  parameter int unsigned SCL_QUARTER = 1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     active_i,
  input  bit_cmd_e cmd_i,
  input  logic     txbit_i,
  input  logic     scl_in_i,
  input  logic     sda_in_i,
  output logic     scl_oe_o,
  output logic     sda_oe_o,
  output logic     done_o,
  output logic     rxbit_o
);

  localparam int unsigned DW = (SCL_QUARTER > 1) ? $clog2(SCL_QUARTER) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCL_QUARTER - 1);

  logic [DW-1:0] div_q;
  logic [1:0]    qcnt_q;
  logic          scl_oe_q, scl_oe_d;
  logic          sda_oe_q, sda_oe_d;
  logic          rxbit_q;
  logic          stall_s;
  logic          qtick_s;
  logic          sample_s;

  // SCL is released during q2/q3; a low reading there means the slave is stretching
  always_comb begin
    stall_s  = active_i && qcnt_q[1] && !scl_in_i;
    qtick_s  = active_i && !stall_s && (div_q == DIV_LAST);
    done_o   = qtick_s && (qcnt_q == 2'd3);
    sample_s = qtick_s && (qcnt_q == 2'd2);
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    if (active_i) begin
      case (cmd_i)
        CMD_START: begin
          scl_oe_d = (qcnt_q == 2'd3);
          sda_oe_d = (qcnt_q != 2'd0);
        end
        CMD_STOP: begin
          scl_oe_d = (qcnt_q == 2'd0);
          sda_oe_d = !qcnt_q[1];
        end
        CMD_WRITE: begin
          scl_oe_d = (qcnt_q == 2'd0) || (qcnt_q == 2'd3);
          sda_oe_d = !txbit_i;
        end
        CMD_READ: begin
          scl_oe_d = (qcnt_q == 2'd0) || (qcnt_q == 2'd3);
          sda_oe_d = 1'b0;
        end
        default: begin
          scl_oe_d = 1'b0;
          sda_oe_d = 1'b0;
        end
      endcase
    end else begin
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q    <= '0;
      qcnt_q   <= 2'd0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      rxbit_q  <= 1'b1;
    end else begin
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
      if (sample_s) begin
        rxbit_q <= sda_in_i;
      end
      if (!active_i) begin
        div_q  <= '0;
        qcnt_q <= 2'd0;
      end else if (!stall_s) begin
        if (div_q == DIV_LAST) begin
          div_q  <= '0;
          qcnt_q <= qcnt_q + 2'd1;
        end else begin
          div_q <= div_q + {{(DW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign scl_oe_o = scl_oe_q;
  assign sda_oe_o = sda_oe_q;
  assign rxbit_o  = rxbit_q;

endmodule

// File: rtl/sensor_top.sv
// I2C master front-end: one single-byte register write or read per start edge,
// with a data_ready pulse on acknowledged completion.
module sensor_top
  import sensor_i2c_pkg::*;
#(
  parameter int unsigned SCL_QUARTER = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       mode,
  input  logic [6:0] sensor_address,
  input  logic [7:0] write_val,
  output logic       data_ready,
  output logic [7:0] read_val,
  inout  wire        master_sda_line,
  inout  wire        master_scl_line
);

  state_e     state_q;
  logic       start_prev_q;
  logic       mode_q;
  logic [6:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] tx_q;
  logic [7:0] rx_shift_q;
  logic [2:0] bit_cnt_q;
  logic       nack_q;
  logic       data_ready_q;
  logic [7:0] read_val_q;

  logic       active_s;
  bit_cmd_e   cmd_s;
  logic       txbit_s;
  logic       bit_done_s;
  logic       rxbit_s;
  logic       scl_oe_s;
  logic       sda_oe_s;

  // Each byte/ack state maps onto one bit-slot primitive
  always_comb begin
    active_s = 1'b1;
    cmd_s    = CMD_READ;
    txbit_s  = 1'b1;
    case (state_q)
      ST_START:                              cmd_s = CMD_START;
      ST_ADDR, ST_WDATA: begin
        cmd_s   = CMD_WRITE;
        txbit_s = tx_q[7];
      end
      ST_ADDR_ACK, ST_WDATA_ACK, ST_RDATA:   cmd_s = CMD_READ;
      ST_MNACK: begin
        cmd_s   = CMD_WRITE;
        txbit_s = NACK;
      end
      ST_STOP:                               cmd_s = CMD_STOP;
      default:                               active_s = 1'b0;
    endcase
  end

  i2c_bit_ctrl #(.SCL_QUARTER(SCL_QUARTER)) u_bit_ctrl (
    .clk_i    (clock),
    .rst_i    (reset),
    .active_i (active_s),
    .cmd_i    (cmd_s),
    .txbit_i  (txbit_s),
    .scl_in_i (master_scl_line),
    .sda_in_i (master_sda_line),
    .scl_oe_o (scl_oe_s),
    .sda_oe_o (sda_oe_s),
    .done_o   (bit_done_s),
    .rxbit_o  (rxbit_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b0;
      mode_q       <= I2C_WRITE;
      addr_q       <= 7'd0;
      wdata_q      <= 8'd0;
      tx_q         <= 8'd0;
      rx_shift_q   <= 8'd0;
      bit_cnt_q    <= 3'd0;
      nack_q       <= 1'b0;
      data_ready_q <= 1'b0;
      read_val_q   <= 8'd0;
    end else begin
      start_prev_q <= start;
      data_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !start_prev_q) begin
            mode_q  <= mode;
            addr_q  <= sensor_address;
            wdata_q <= write_val;
            nack_q  <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (bit_done_s) begin
            tx_q      <= addr_byte(addr_q, mode_q);
            bit_cnt_q <= 3'd0;
            state_q   <= ST_ADDR;
          end
        end
        ST_ADDR, ST_WDATA: begin
          if (bit_done_s) begin
            tx_q      <= {tx_q[6:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_WDATA_ACK;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (bit_done_s) begin
            bit_cnt_q <= 3'd0;
            if (rxbit_s == NACK) begin
              nack_q  <= 1'b1;
              state_q <= ST_STOP;
            end else if (mode_q == I2C_READ) begin
              state_q <= ST_RDATA;
            end else begin
              tx_q    <= wdata_q;
              state_q <= ST_WDATA;
            end
          end
        end
        ST_WDATA_ACK: begin
          if (bit_done_s) begin
            nack_q  <= (rxbit_s == NACK);
            state_q <= ST_STOP;
          end
        end
        ST_RDATA: begin
          if (bit_done_s) begin
            rx_shift_q <= {rx_shift_q[6:0], rxbit_s};
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= ST_MNACK;
            end
          end
        end
        ST_MNACK: begin
          if (bit_done_s) begin
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_done_s) begin
            data_ready_q <= !nack_q;
            if (!nack_q && (mode_q == I2C_READ)) begin
              read_val_q <= rx_shift_q;
            end
            state_q <= ST_DONE;
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Open-drain: only ever pull low, the external pull-up supplies the high level
  assign master_sda_line = sda_oe_s ? 1'b0 : 1'bz;
  assign master_scl_line = scl_oe_s ? 1'b0 : 1'bz;

  assign data_ready = data_ready_q;
  assign read_val   = read_val_q;

endmodule

// File: tb/tb_sensor_top.sv
// Directed bench for sensor_top with an inline I2C slave model on the shared
// open-drain bus; the slave can ACK, capture bytes, return a measurement and stretch SCL.
module tb_sensor_top;
  import sensor_i2c_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [6:0] sensor_address = 7'd0;
  logic [7:0] write_val = 8'd0;
  logic       data_ready;
  logic [7:0] read_val;
  wire        sda;
  wire        scl;

  pullup (sda);
  pullup (scl);

  logic       s_en = 1'b1;
  logic [6:0] s_my_addr = 7'h70;
  logic [7:0] s_meas = 8'h00;
  logic       s_stretch_en = 1'b0;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ACKA, S_WR, S_ACKW, S_RD, S_MACK, S_IGN} sph_e;
  sph_e       s_phase;
  logic       s_prev_scl, s_prev_sda;
  logic [7:0] s_sh;
  logic [3:0] s_cnt;
  logic       s_rw;
  logic       s_sda_low;
  logic [4:0] s_stretch;
  logic       s_mnack;
  logic [7:0] s_addr_seen = 8'h00;
  logic [7:0] s_wr_seen = 8'h00;
  int         s_start_cnt = 0;
  int         s_stop_cnt = 0;
  int         s_wr_cnt = 0;

  int errors = 0;
  int checks = 0;

  assign sda = s_sda_low ? 1'b0 : 1'bz;
  assign scl = (s_stretch != 5'd0) ? 1'b0 : 1'bz;

  always #5 clock = ~clock;

  sensor_top #(.SCL_QUARTER(1)) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .mode            (mode),
    .sensor_address  (sensor_address),
    .write_val       (write_val),
    .data_ready      (data_ready),
    .read_val        (read_val),
    .master_sda_line (sda),
    .master_scl_line (scl)
  );

  // Slave bus-functional model, oversampling the bus on the system clock
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      s_phase    <= S_IDLE;
      s_prev_scl <= 1'b1;
      s_prev_sda <= 1'b1;
      s_sh       <= 8'h00;
      s_cnt      <= 4'd0;
      s_rw       <= 1'b0;
      s_sda_low  <= 1'b0;
      s_stretch  <= 5'd0;
      s_mnack    <= 1'b0;
    end else begin
      s_prev_scl <= scl;
      s_prev_sda <= sda;
      if (s_stretch != 5'd0) s_stretch <= s_stretch - 5'd1;
      if (s_prev_scl && scl && s_prev_sda && !sda) begin
        s_start_cnt <= s_start_cnt + 1;
        s_phase     <= S_ADDR;
        s_cnt       <= 4'd0;
        s_sda_low   <= 1'b0;
      end else if (s_prev_scl && scl && !s_prev_sda && sda) begin
        s_stop_cnt <= s_stop_cnt + 1;
        s_phase    <= S_IDLE;
        s_sda_low  <= 1'b0;
      end else if (!s_prev_scl && scl) begin
        case (s_phase)
          S_ADDR, S_WR: begin
            s_sh  <= {s_sh[6:0], sda};
            s_cnt <= s_cnt + 4'd1;
          end
          S_MACK:  s_mnack <= sda;
          default: ;
        endcase
      end else if (s_prev_scl && !scl) begin
        case (s_phase)
          S_ADDR: if (s_cnt == 4'd8) begin
            s_addr_seen <= s_sh;
            s_rw        <= s_sh[0];
            if (s_en && (s_sh[7:1] == s_my_addr)) begin
              s_sda_low <= 1'b1;
              s_phase   <= S_ACKA;
              if (s_stretch_en) s_stretch <= 5'd11;
            end else begin
              s_phase <= S_IGN;
            end
          end
          S_ACKA: begin
            s_cnt <= (s_rw) ? 4'd1 : 4'd0;
            s_sda_low <= s_rw ? !s_meas[7] : 1'b0;
            s_phase <= s_rw ? S_RD : S_WR;
          end
          S_WR: if (s_cnt == 4'd8) begin
            s_wr_seen <= s_sh;
            s_wr_cnt  <= s_wr_cnt + 1;
            s_sda_low <= 1'b1;
            s_phase   <= S_ACKW;
          end
          S_ACKW: begin
            s_sda_low <= 1'b0;
            s_phase   <= S_IGN;
          end
          S_RD: if (s_cnt == 4'd8) begin
            s_sda_low <= 1'b0;
            s_phase   <= S_MACK;
          end else begin
            s_sda_low <= !s_meas[3'd7 - s_cnt[2:0]];
            s_cnt     <= s_cnt + 4'd1;
          end
          S_MACK:  s_phase <= S_IGN;
          default: ;
        endcase
      end
    end
  end

  // One transaction: start edge at the next posedge, inputs scrambled mid-flight
  task automatic run_txn(input logic m, input logic [6:0] a, input logic [7:0] w,
                         input int ncyc, input bit hold,
                         output int first_rdy, output int pulses, output logic [7:0] rv_at_rdy);
    @(negedge clock);
    mode = m; sensor_address = a; write_val = w; start = 1'b1;
    first_rdy = 0; pulses = 0; rv_at_rdy = 8'h00;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (!hold) start = 1'b0;
      if (c == 5) begin
        mode = ~m; sensor_address = ~a; write_val = ~w;
      end
      if (data_ready === 1'b1) begin
        pulses++;
        if (first_rdy == 0) begin
          first_rdy = c;
          rv_at_rdy = read_val;
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready: got %b expected 0", data_ready); end
    checks++; if (read_val !== 8'h00) begin errors++; $display("FAIL reset_read_val: got %h expected 00", read_val); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b expected 1", sda); end
    checks++; if (scl !== 1'b1) begin errors++; $display("FAIL reset_scl: got %b expected 1", scl); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_write();
    int fr, pc, st0, sp0;
    logic [7:0] rv;
    st0 = s_start_cnt; sp0 = s_stop_cnt;
    run_txn(1'b0, 7'h70, 8'hF2, 120, 1'b0, fr, pc, rv);
    checks++; if (fr !== 81) begin errors++; $display("FAIL write_latency: got %0d expected 81", fr); end
    checks++; if (pc !== 1) begin errors++; $display("FAIL write_pulses: got %0d expected 1", pc); end
    checks++; if (s_addr_seen !== 8'hE0) begin errors++; $display("FAIL write_addr_byte: got %h expected e0", s_addr_seen); end
    checks++; if (s_wr_seen !== 8'hF2) begin errors++; $display("FAIL write_data_byte: got %h expected f2", s_wr_seen); end
    checks++; if (s_start_cnt - st0 !== 1) begin errors++; $display("FAIL write_starts: got %0d expected 1", s_start_cnt - st0); end
    checks++; if (s_stop_cnt - sp0 !== 1) begin errors++; $display("FAIL write_stops: got %0d expected 1", s_stop_cnt - sp0); end
    checks++; if (read_val !== 8'h00) begin errors++; $display("FAIL write_read_val: got %h expected 00", read_val); end
  endtask

  task automatic test_read();
    int fr, pc, sp0;
    logic [7:0] rv;
    s_meas = 8'hF0; sp0 = s_stop_cnt;
    run_txn(1'b1, 7'h70, 8'h00, 120, 1'b0, fr, pc, rv);
    checks++; if (fr !== 81) begin errors++; $display("FAIL read_latency: got %0d expected 81", fr); end
    checks++; if (pc !== 1) begin errors++; $display("FAIL read_pulses: got %0d expected 1", pc); end
    checks++; if (s_addr_seen !== 8'hE1) begin errors++; $display("FAIL read_addr_byte: got %h expected e1", s_addr_seen); end
    checks++; if (s_mnack !== 1'b1) begin errors++; $display("FAIL read_master_nack: got %b expected 1", s_mnack); end
    checks++; if (rv !== 8'hF0) begin errors++; $display("FAIL read_val_at_ready: got %h expected f0", rv); end
    checks++; if (s_stop_cnt - sp0 !== 1) begin errors++; $display("FAIL read_stops: got %0d expected 1", s_stop_cnt - sp0); end
  endtask

  task automatic test_addr_mismatch();
    int fr, pc, sp0, wc0;
    logic [7:0] rv;
    s_my_addr = 7'h71; s_meas = 8'h3C; sp0 = s_stop_cnt; wc0 = s_wr_cnt;
    run_txn(1'b1, 7'h70, 8'h00, 120, 1'b0, fr, pc, rv);
    checks++; if (pc !== 0) begin errors++; $display("FAIL nack_pulses: got %0d expected 0", pc); end
    checks++; if (s_addr_seen !== 8'hE1) begin errors++; $display("FAIL nack_addr_byte: got %h expected e1", s_addr_seen); end
    checks++; if (s_stop_cnt - sp0 !== 1) begin errors++; $display("FAIL nack_stops: got %0d expected 1", s_stop_cnt - sp0); end
    checks++; if (read_val !== 8'hF0) begin errors++; $display("FAIL nack_read_val: got %h expected f0", read_val); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL nack_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
    s_my_addr = 7'h70;
  endtask

  task automatic test_held_start();
    int fr, pc, st0;
    logic [7:0] rv;
    st0 = s_start_cnt;
    run_txn(1'b0, 7'h70, 8'h5A, 200, 1'b1, fr, pc, rv);
    checks++; if (pc !== 1) begin errors++; $display("FAIL held_pulses: got %0d expected 1", pc); end
    checks++; if (s_start_cnt - st0 !== 1) begin errors++; $display("FAIL held_starts: got %0d expected 1", s_start_cnt - st0); end
    checks++; if (s_wr_seen !== 8'h5A) begin errors++; $display("FAIL held_data_byte: got %h expected 5a", s_wr_seen); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL held_sda_idle: got %b expected 1", sda); end
    checks++; if (scl !== 1'b1) begin errors++; $display("FAIL held_scl_idle: got %b expected 1", scl); end
  endtask

  task automatic test_reset_mid();
    int fr, pc, sp0, wc0;
    logic [7:0] rv;
    sp0 = s_stop_cnt; wc0 = s_wr_cnt;
    @(negedge clock);
    mode = 1'b0; sensor_address = 7'h70; write_val = 8'hC3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (49) @(negedge clock);
    checks++; if (dut.state_q !== ST_WDATA) begin errors++; $display("FAIL mid_in_wdata: got %0d expected %0d", dut.state_q, ST_WDATA); end
    #2 reset = 1'b1;
    #1;
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL mid_sda_released: got %b expected 1", sda); end
    checks++; if (scl !== 1'b1) begin errors++; $display("FAIL mid_scl_released: got %b expected 1", scl); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL mid_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    pc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (data_ready !== 1'b0) pc++;
    end
    checks++; if (pc !== 0) begin errors++; $display("FAIL mid_no_ready: got %0d expected 0", pc); end
    checks++; if (s_stop_cnt - sp0 !== 0) begin errors++; $display("FAIL mid_no_stop: got %0d expected 0", s_stop_cnt - sp0); end
    checks++; if (s_wr_cnt - wc0 !== 0) begin errors++; $display("FAIL mid_no_byte: got %0d expected 0", s_wr_cnt - wc0); end
    run_txn(1'b0, 7'h70, 8'h3C, 120, 1'b0, fr, pc, rv);
    checks++; if (fr !== 81) begin errors++; $display("FAIL mid_recover_latency: got %0d expected 81", fr); end
    checks++; if (s_wr_seen !== 8'h3C) begin errors++; $display("FAIL mid_recover_byte: got %h expected 3c", s_wr_seen); end
  endtask

  task automatic test_stretch();
    int fr, pc;
    logic [7:0] rv;
    s_stretch_en = 1'b1;
    run_txn(1'b0, 7'h70, 8'h81, 120, 1'b0, fr, pc, rv);
    s_stretch_en = 1'b0;
    checks++; if (fr !== 91) begin errors++; $display("FAIL stretch_latency: got %0d expected 91", fr); end
    checks++; if (pc !== 1) begin errors++; $display("FAIL stretch_pulses: got %0d expected 1", pc); end
    checks++; if (s_wr_seen !== 8'h81) begin errors++; $display("FAIL stretch_data_byte: got %h expected 81", s_wr_seen); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_mismatch();
    test_held_start();
    test_reset_mid();
    test_stretch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sensor_top.md
# sensor_top

I2C master front-end for the sensor interface. A rising edge on `start` launches one complete I2C transaction to a 7-bit sensor address: either a single-byte register write of `write_val`, or a single-byte read that is returned on `read_val`. The block drives open-drain SDA/SCL lines shared with the external sensor (or the `slave` bus-functional model in simulation). Completion is flagged by a one-cycle `data_ready` pulse.

## Interface
- `SCL_QUARTER`, default 1: system clocks per quarter SCL period (SCL period = 4·SCL_QUARTER clocks); must be ≥1.
- `clock` in 1: single system clock; all logic on its rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `start` in 1: transaction request; its rising edge is sampled while IDLE.
- `mode` in 1: 0 = write, 1 = read; latched at start.
- `sensor_address` in 7: target address; latched at start.
- `write_val` in 8: byte written in write mode; latched at start.
- `data_ready` out 1: one-cycle pulse on successful completion.
- `read_val` out 8: byte received in read mode; holds until the next successful read.
- `master_sda_line` inout 1: open-drain SDA; drives 0 or Z, external pull-up.
- `master_scl_line` inout 1: open-drain SCL; drives 0 or Z, external pull-up.

## Operation
- States: IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, MNACK, STOP, DONE.
- IDLE: both lines released (Z). A `start` rising edge (0→1 relative to the previous cycle) latches mode/address/data and enters START. Holding `start` high never retriggers a transaction.
- START: SDA falls while SCL is high, then SCL is pulled low.
- ADDR: shifts {sensor_address, mode} MSB first. The address byte is 0xE0 for a write to 0x70 and 0xE1 for a read from 0x70.
- ADDR_ACK: SDA is released and sampled with SCL high. Low = ACK; high = NACK, which goes to STOP.
- After an ACK, mode 0 goes to WDATA and mode 1 goes to RDATA.
- WDATA: shifts `write_val` MSB first, then moves to WDATA_ACK. A NACK on that byte goes to STOP.
- RDATA: SDA is released and 8 bits are sampled MSB first into a shift register. MNACK then drives SDA high, i.e. the master NACKs the single byte.
- STOP: SDA low while SCL low, then SCL is released, then SDA rises while SCL is high.
- DONE: one cycle. `data_ready` = 1 only if no NACK occurred; `read_val` is updated from the shift register in read mode. Then IDLE.
- NACK path: still issues STOP, no `data_ready` pulse, `read_val` unchanged.
- SDA changes only while SCL is low, except in the START and STOP conditions.
- Clock stretching: after releasing SCL, the quarter counter stalls while `master_scl_line` reads low.
- `mode`, `sensor_address` and `write_val` changes mid-transaction are ignored.

## Timing
- Each bit takes 4 quarters:
  - q0: SCL low, SDA updated.
  - q1: SCL released.
  - q2: SCL high, SDA sampled.
  - q3: SCL high.
  - Then SCL is pulled low.
- START and STOP each take 4 quarters.
- Latency with no stretching and SCL_QUARTER=1:
  - `start` edge sampled in cycle N → START begins at N+1.
  - Transaction = START + 18 bit-slots (address, ack, data, ack/nack) + STOP = 80 cycles.
  - `data_ready` high in cycle N+81 for exactly one cycle.
- General latency: N+1+80·SCL_QUARTER.
- Reset values: state IDLE, both lines Z, `data_ready`=0, `read_val`=0x00, counters 0.
- Reset mid-transaction: lines released within the same cycle (asynchronous). No STOP is generated.

## Structure
- Shared package `sensor_i2c_pkg`: state enum, `I2C_WRITE`=0/`I2C_READ`=1 constants, ACK/NACK constants.
- Natural sub-module `i2c_bit_ctrl`, owning:
  - the quarter/phase counter;
  - SCL generation and stretch detection;
  - the START, STOP, bit-write and bit-read primitives.
- The top FSM sequences bytes and ACKs; estimated 150–300 lines total.
- Companion model `slave`, ports reset_n, en, my_addr[6:0], measurement[7:0], scl, sda:
  - ACKs its own address only when `en`=1;
  - accepts one write byte;
  - returns `measurement` on a read.

## Test plan
- Write test: mode=0, addr 0x70, write_val 0xF2, start edge.
  - Slave receives 0xE0 then 0xF2, ACKs both.
  - STOP is generated; `data_ready` pulses once at N+81.
- Read test: mode=1, addr 0x70, slave measurement 0xF0.
  - Bus shows 0xE1 and the master NACKs the data byte.
  - `read_val`=0xF0 with the `data_ready` pulse.
- Address mismatch: slave at 0x71, master targets 0x70.
  - NACK after the address byte, then STOP.
  - No `data_ready`; `read_val` unchanged.
- `start` held high for 2000 ns: exactly one transaction; lines idle (Z/high) afterwards.
- Reset asserted during WDATA: lines released immediately, state IDLE, `data_ready` stays 0. A new start edge then completes normally.
- Slave stretches SCL low for 10 cycles during ADDR_ACK: master stalls, still completes, and `data_ready` is delayed by exactly 10 cycles.
